dmem_dump_reader: RTL and testbench
===================================

Name: dmem_dump_reader

Overview:
- Memory-side reader that sweeps the 64-word data memory after a program run and streams each word out over a valid/ready channel.
- Also accumulates a running checksum of the words it streams.
- Sits in `top` beside `dmem`. While busy, it takes the dmem read address through a top-level mux selected by `mem_sel`.
- Gives the bench, or a later debug port, the reading end of what the CPU wrote through `memwrite`/`dataadr`/`writedata`.

Parameters:
- DEPTH, 64: number of words to read; must be at most 64, the dmem size.
- BASE_ADDR, 32'h0: byte address of the first word; must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- mem_sel  output  1  high while the block owns the dmem read address; top muxes `mem_addr` into the dmem address input.
- mem_addr  output  32  byte address presented to dmem; combinational read.
- mem_rd  input  32  dmem read data, valid in the same cycle as `mem_addr`.
- out_valid  output  1  output word available.
- out_ready  input  1  consumer accepts the word.
- out_addr  output  32  byte address of the word on `out_data`.
- out_data  output  32  word read from dmem.
- out_last  output  1  high with the final word (index DEPTH-1).
- busy  output  1  high in READ and SEND.
- done  output  1  one-cycle pulse after the last handshake.
- checksum  output  32  running 32-bit wrapping sum of accepted words.

Behaviour:
- Reset (synchronous, active-high): on a reset-high edge, state returns to IDLE.
  - Cleared to 0: index, `mem_sel`, `mem_addr`, `out_valid`, `out_addr`, `out_data`, `out_last`, `busy`, `done`, `checksum`.
  - Reset overrides any in-flight dump; no `done` pulse is produced.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - On `start`=1: index clears to 0, `checksum` clears to 0, go to READ.
  - `start` is ignored in every other state.
- READ:
  - `mem_sel`=1 and `mem_addr` = BASE_ADDR + 4·index, both driven combinationally from state and index.
  - At the clock edge: `out_data` <= `mem_rd`, `out_addr` <= `mem_addr`, `out_last` <= (index == DEPTH-1), `out_valid` <= 1; go to SEND.
- SEND:
  - `mem_sel`=1, so dmem is held off the CPU for the whole dump.
  - `out_valid`, `out_data`, `out_addr` and `out_last` stay stable until the handshake (`out_valid` & `out_ready`).
  - On handshake: `checksum` <= `checksum` + `out_data`, taken modulo 2^32; `out_valid` <= 0.
  - After the handshake, if `out_last`=1, go to DONE. Otherwise index increments and the block returns to READ.
  - Throughput: at most 1 word per 2 cycles. Latency from `start` to first `out_valid` is 2 edges.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `checksum` holds its final value until the next `start` or reset.
- `busy` = (state is READ or SEND).
- `mem_sel` = `busy`; it is 0 in IDLE and DONE.
- Index is ceil(log2(DEPTH)) bits wide and never wraps. The transition to DONE happens at index DEPTH-1.
- `out_ready` held high: the block streams continuously, with `out_valid` alternating 0/1.
- `out_ready` held low: the block stalls in SEND indefinitely, with no change to `checksum` or `mem_addr`.
- dmem writes by the CPU during a dump are outside the contract; the CPU is expected to be halted or in reset.
- DEPTH=1: a single READ then SEND with `out_last`=1, then DONE.

Test Plan:
1. Load dmem with RAM[i] = i+1, i = 0..63; pulse `start` with `out_ready`=1.
   - 64 handshakes occur with `out_addr` = 0x00, 0x04, …, 0xFC and `out_data` = 1..64.
   - `out_last` is high only at 0xFC; `done` pulses once; `checksum` = 0x820 (2080).
2. Same memory image; `out_ready` toggles pseudo-randomly.
   - `out_data` and `out_addr` never change while `out_valid`=1 and `out_ready`=0.
   - Final `checksum` is still 0x820; no word is dropped or duplicated.
3. Word 21 (byte 0x54) = 32'h7, all other words 0.
   - Exactly one nonzero word, at `out_addr` 0x54 with `out_data` 0x7; `checksum` = 7.
4. All 64 words = 32'hFFFFFFFF.
   - `checksum` wraps to 32'hFFFFFFC0; `out_last` is high on the 64th word.
5. Assert `reset` for one cycle while in SEND at index 10.
   - Next cycle: IDLE, all outputs 0, no `done` pulse.
   - A following `start` restarts from 0x00 with `checksum` 0.
6. Pulse `start` again while busy, and set DEPTH=1 with BASE_ADDR=0x54.
   - The extra `start` is ignored: the dump is still 64 words.
   - With DEPTH=1: exactly one handshake at 0x54 with `out_last`=1, then `done`; `mem_sel` is 0 before and after.

Source files
------------

// File: rtl/dmem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_dump_reader
//  Brief    : Sweeps DEPTH words of the data memory after a program run,
//             streams each word over a valid/ready channel and keeps a
//             running 32-bit wrapping checksum of the accepted words.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_dump_reader #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        mem_sel,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum
);

   // Index width; a one-word dump still needs a 1-bit index.
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] c_LAST_IDX = IW'(DEPTH - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_READ = 2'd1;
   localparam logic [1:0] c_S_SEND = 2'd2;
   localparam logic [1:0] c_S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_addr_q, out_addr_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic [31:0]   checksum_q, checksum_d;

   logic          w_hs;
   logic [31:0]   w_word_addr;

   assign w_hs        = out_valid_q & out_ready;
   assign w_word_addr = BASE_ADDR + {{(30 - IW){1'b0}}, idx_q, 2'b00};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start only matters while idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_S_IDLE: if (start) state_d = c_S_READ;
         c_S_READ: state_d = c_S_SEND;
         c_S_SEND: if (w_hs) state_d = out_last_q ? c_S_DONE : c_S_READ;
         c_S_DONE: state_d = c_S_IDLE;
         default:  state_d = c_S_IDLE;
      endcase
   end

   // Outputs decoded from state; the memory address is forced to 0 when idle.
   always_comb begin
      busy     = (state_q == c_S_READ) || (state_q == c_S_SEND);
      mem_sel  = busy;
      done     = (state_q == c_S_DONE);
      mem_addr = busy ? w_word_addr : 32'h0;
   end

   // Datapath next-state: capture in READ, hold through SEND until accepted.
   always_comb begin
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      checksum_d  = checksum_q;
      case (state_q)
         c_S_IDLE: begin
            if (start) begin
               idx_d      = '0;
               checksum_d = 32'h0;
            end
         end
         c_S_READ: begin
            out_data_d  = mem_rd;
            out_addr_d  = w_word_addr;
            out_last_d  = (idx_q == c_LAST_IDX);
            out_valid_d = 1'b1;
         end
         c_S_SEND: begin
            if (w_hs) begin
               checksum_d  = checksum_q + out_data_q;
               out_valid_d = 1'b0;
               // The last index never increments, so the index cannot wrap.
               if (!out_last_q) idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= 32'h0;
         out_data_q  <= 32'h0;
         out_last_q  <= 1'b0;
         checksum_q  <= 32'h0;
      end else begin
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         checksum_q  <= checksum_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign checksum  = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_dump_reader
//  Brief    : Self-checking bench for dmem_dump_reader (64-word sweep and a
//             one-word instance at 0x54) against a behavioural memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_dump_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, out_ready;
   logic        mem_sel, out_valid, out_last, busy, done;
   logic [31:0] mem_addr, mem_rd, out_addr, out_data, checksum;

   logic        start1, out_ready1;
   logic        mem_sel1, out_valid1, out_last1, busy1, done1;
   logic [31:0] mem_addr1, mem_rd1, out_addr1, out_data1, checksum1;

   logic [31:0] mem [64];
   assign mem_rd  = mem[mem_addr[7:2]];
   assign mem_rd1 = mem[mem_addr1[7:2]];

   dmem_dump_reader u_dut (
      .clk(clk), .reset(reset), .start(start), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
   );

   dmem_dump_reader #(.DEPTH(1), .BASE_ADDR(32'h54)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .mem_sel(mem_sel1),
      .mem_addr(mem_addr1), .mem_rd(mem_rd1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_addr(out_addr1), .out_data(out_data1),
      .out_last(out_last1), .busy(busy1), .done(done1), .checksum(checksum1)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          pat;      // 0: i+1, 1: only word 21 = 7, 2: all ones
      int          rmode;    // 0: ready held high, 1: random ready
      bit          extra;    // pulse start again mid-dump
      logic [31:0] exp_sum;
      int          exp_nz;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat_word(input int pat, input int i);
      case (pat)
         0:       return 32'(i + 1);
         1:       return (i == 21) ? 32'h7 : 32'h0;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic load_mem(input int pat);
      for (int i = 0; i < 64; i++) mem[i] = pat_word(pat, i);
   endtask

   task automatic run_dump(input vec_t v);
      int it, hs, nz, dn, post, first_v;
      bit fin, pv, pr;
      logic [31:0] pd, pa, pm;
      load_mem(v.pat);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      it = 1; hs = 0; nz = 0; dn = 0; post = 0; first_v = -1;
      fin = 0; pv = 0; pr = 0; pd = 0; pa = 0; pm = 0;
      while (!fin && it < 3000) begin
         if (first_v < 0 && out_valid) first_v = it;
         if (pv && !pr) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
            chk("stall_addr", out_addr, pa);
            chk("stall_mem_addr", mem_addr, pm);
         end
         if (done) dn++;
         out_ready = (v.rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            chk("hs_addr", out_addr, 32'(hs * 4));
            chk("hs_data", out_data, pat_word(v.pat, hs));
            chk("hs_last", out_last, (hs == 63) ? 1 : 0);
            chk("hs_mem_sel", mem_sel, 1);
            if (out_data != 0) nz++;
            hs++;
         end
         pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pm = mem_addr;
         if (dn > 0) post++;
         if (post >= 4) fin = 1;
         start = (v.extra && it == 20) ? 1'b1 : 1'b0;
         @(negedge clk);
         it++;
      end
      start = 1'b0;
      chk("timeout", 32'(fin), 1);
      chk("first_valid_latency", 32'(first_v), 2);
      chk("handshakes", 32'(hs), 64);
      chk("nonzero_words", 32'(nz), 32'(v.exp_nz));
      chk("done_pulses", 32'(dn), 1);
      chk("checksum", checksum, v.exp_sum);
      chk("idle_busy", busy, 0);
      chk("idle_mem_sel", mem_sel, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_sel"}, mem_sel, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_checksum"}, checksum, 0);
   endtask

   initial begin
      int k, hs1, dn1;
      bit seen;
      vecs[0] = '{pat: 0, rmode: 0, extra: 0, exp_sum: 32'h0000_0820, exp_nz: 64};
      vecs[1] = '{pat: 0, rmode: 1, extra: 0, exp_sum: 32'h0000_0820, exp_nz: 64};
      vecs[2] = '{pat: 1, rmode: 0, extra: 0, exp_sum: 32'h0000_0007, exp_nz: 1};
      vecs[3] = '{pat: 2, rmode: 0, extra: 0, exp_sum: 32'hFFFF_FFC0, exp_nz: 64};
      vecs[4] = '{pat: 0, rmode: 0, extra: 1, exp_sum: 32'h0000_0820, exp_nz: 64};

      reset = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b1;
      load_mem(0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_all_zero("reset");

      foreach (vecs[i]) run_dump(vecs[i]);

      // Reset while waiting in SEND at index 10 (byte 0x28).
      load_mem(0);
      @(negedge clk);
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0; k = 0;
      while (!seen && k < 200) begin
         if (out_valid && out_addr == 32'h28) seen = 1;
         else begin @(negedge clk); k++; end
      end
      chk("reach_idx10", 32'(seen), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_all_zero("midreset");
      dn1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy) dn1++;
      end
      chk("midreset_no_done", 32'(dn1), 0);
      run_dump(vecs[0]);

      // One-word instance reading byte 0x54.
      load_mem(1);
      @(negedge clk);
      chk("d1_sel_before", mem_sel1, 0);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      hs1 = 0; dn1 = 0;
      for (int i = 0; i < 10; i++) begin
         if (done1) dn1++;
         if (out_valid1 && out_ready1) begin
            chk("d1_addr", out_addr1, 32'h54);
            chk("d1_data", out_data1, 32'h7);
            chk("d1_last", out_last1, 1);
            hs1++;
         end
         @(negedge clk);
      end
      chk("d1_handshakes", 32'(hs1), 1);
      chk("d1_done", 32'(dn1), 1);
      chk("d1_checksum", checksum1, 32'h7);
      chk("d1_sel_after", mem_sel1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
